// File: rtl/gpu_pkg.sv
// gpu_pkg: state encodings, default widths and small helpers shared by the
// GPU VRAM clients (port arbiter, renderer fetch units, CPU bridge).
package gpu_pkg;

  localparam int GPU_VRAM_ADDR_W = 14;
  localparam int GPU_VRAM_DATA_W = 32;
  localparam int GPU_VRAM_RD_LAT = 1;
  localparam int ARB_WAIT_W      = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_PEND   = 2'd1,
    ARB_RDWAIT = 2'd2
  } arb_state_e;

  // Saturating increment for the CPU wait-cycle counter.
  function automatic logic [ARB_WAIT_W-1:0] wait_sat_inc(input logic [ARB_WAIT_W-1:0] v);
    return (&v) ? v : v + {{(ARB_WAIT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-deep 1-bit shift register that follows a read through
// the VRAM latency so the issuer can recognise its own data on the way out.
module rd_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tag_i,
  output logic tag_o
);

  logic [DEPTH-1:0] stage_q;

  generate
    if (DEPTH == 1) begin : g_single
      // Single stage: the tag simply waits one cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= 1'b0;
        else     stage_q <= tag_i;
      end
    end else begin : g_multi
      // Shift the tag one stage per cycle; a clear drops any read in flight.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= '0;
        else     stage_q <= {stage_q[DEPTH-2:0], tag_i};
      end
    end
  endgenerate

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one synchronous VRAM port between GPU read fetches
// (absolute priority, zero added latency) and CPU start/done accesses that
// only use cycles the GPU leaves idle.
module vram_port_arbiter
  import gpu_pkg::*;
#(
  parameter int ADDR_W = GPU_VRAM_ADDR_W,
  parameter int DATA_W = GPU_VRAM_DATA_W,
  parameter int RD_LAT = GPU_VRAM_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gpu_req,
  input  logic [ADDR_W-1:0] gpu_addr,
  output logic [DATA_W-1:0] gpu_q,
  input  logic              cpu_start,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_d,
  output logic              vram_we,
  input  logic [DATA_W-1:0] vram_q,
  output logic [15:0]       wait_max
);

  arb_state_e              state_q;
  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       data_q;
  logic [ADDR_W-1:0]       last_addr_q;
  logic [ARB_WAIT_W-1:0]   wait_cnt_q;
  logic [ARB_WAIT_W-1:0]   wait_cnt_d;
  logic [ARB_WAIT_W-1:0]   wait_max_q;
  logic [DATA_W-1:0]       cpu_rdata_q;
  logic                    done_q;
  logic                    busy_q;
  logic                    cpu_grant;
  logic                    tag_issue;
  logic                    tag_out;

  // The CPU owns the port only in PEND cycles the GPU does not claim.
  assign cpu_grant  = (state_q == ARB_PEND) && !gpu_req;
  assign tag_issue  = cpu_grant && !we_q;
  assign wait_cnt_d = wait_sat_inc(wait_cnt_q);

  // Port mux: GPU first, then a granted CPU access, else hold the last address.
  always_comb begin
    vram_addr = last_addr_q;
    vram_we   = 1'b0;
    if (gpu_req) begin
      vram_addr = gpu_addr;
    end else if (cpu_grant) begin
      vram_addr = addr_q;
      vram_we   = we_q;
    end
  end

  // Write data only matters while vram_we is high, so the latched word is
  // driven permanently.
  assign vram_d   = data_q;
  assign gpu_q    = vram_q;
  assign cpu_q    = cpu_rdata_q;
  assign cpu_done = done_q;
  assign cpu_busy = busy_q;
  assign wait_max = wait_max_q;

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst   (reset),
    .tag_i (tag_issue),
    .tag_o (tag_out)
  );

  // Control FSM with registered handshake outputs and wait statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      last_addr_q <= '0;
      wait_cnt_q  <= '0;
      wait_max_q  <= '0;
      cpu_rdata_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      last_addr_q <= vram_addr;
      // busy covers the done cycle itself, then drops.
      if (done_q) busy_q <= 1'b0;

      // The returning tag alone identifies CPU read data on vram_q.
      if (tag_out) begin
        cpu_rdata_q <= vram_q;
        done_q      <= 1'b1;
        state_q     <= ARB_IDLE;
      end else begin
        case (state_q)
          ARB_IDLE: begin
            if (cpu_start && !busy_q) begin
              we_q       <= cpu_we;
              addr_q     <= cpu_addr;
              data_q     <= cpu_data;
              wait_cnt_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= ARB_PEND;
            end
          end
          ARB_PEND: begin
            if (gpu_req) begin
              wait_cnt_q <= wait_cnt_d;
            end else begin
              if (wait_cnt_q > wait_max_q) wait_max_q <= wait_cnt_q;
              if (we_q) begin
                done_q  <= 1'b1;
                state_q <= ARB_IDLE;
              end else begin
                state_q <= ARB_RDWAIT;
              end
            end
          end
          ARB_RDWAIT: begin
            state_q <= ARB_RDWAIT;
          end
          default: state_q <= ARB_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed per-cycle vectors for the VRAM port arbiter
// against a behavioural VRAM with a two-cycle read latency.
module tb_vram_port_arbiter;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          gpu_req;
  logic [AW-1:0] gpu_addr;
  logic [DW-1:0] gpu_q;
  logic          cpu_start;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic [DW-1:0] cpu_q;
  logic          cpu_done;
  logic          cpu_busy;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_d;
  logic          vram_we;
  logic [DW-1:0] vram_q;
  logic [15:0]   wait_max;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  vram_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .RD_LAT (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .gpu_req   (gpu_req),
    .gpu_addr  (gpu_addr),
    .gpu_q     (gpu_q),
    .cpu_start (cpu_start),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_q     (cpu_q),
    .cpu_done  (cpu_done),
    .cpu_busy  (cpu_busy),
    .vram_addr (vram_addr),
    .vram_d    (vram_d),
    .vram_we   (vram_we),
    .vram_q    (vram_q),
    .wait_max  (wait_max)
  );

  // Background contents of every VRAM word until written.
  function automatic logic [31:0] pat(input logic [13:0] a);
    return 32'hA500_0000 | {18'd0, a};
  endfunction

  // Behavioural VRAM: read-before-write, LAT register stages on q.
  logic          fill;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] q_pipe [LAT];
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(14'(i));
    end else if (vram_we) begin
      mem[vram_addr] <= vram_d;
    end
    q_pipe[0] <= mem[vram_addr];
    for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign vram_q = q_pipe[LAT-1];

  typedef struct {
    logic        g;
    logic [13:0] ga;
    logic        s;
    logic        w;
    logic [13:0] a;
    logic [31:0] d;
    logic        e_we;
    logic [13:0] e_addr;
    logic [31:0] e_d;
    logic        e_done;
    logic        e_busy;
    logic [15:0] e_wm;
    logic [31:0] e_q;
    logic        chk_g;
    logic [31:0] e_g;
  } vec_t;

  function automatic vec_t mkv(logic g, logic [13:0] ga, logic s, logic w, logic [13:0] a,
                               logic [31:0] d, logic e_we, logic [13:0] e_addr, logic [31:0] e_d,
                               logic e_done, logic e_busy, logic [15:0] e_wm, logic [31:0] e_q,
                               logic chk_g, logic [31:0] e_g);
    vec_t v;
    v.g = g; v.ga = ga; v.s = s; v.w = w; v.a = a; v.d = d;
    v.e_we = e_we; v.e_addr = e_addr; v.e_d = e_d; v.e_done = e_done; v.e_busy = e_busy;
    v.e_wm = e_wm; v.e_q = e_q; v.chk_g = chk_g; v.e_g = e_g;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive just after the rising edge, observe at the falling edge.
  task automatic cyc(input logic g, input logic [13:0] ga, input logic s, input logic w,
                     input logic [13:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    gpu_req = g; gpu_addr = ga; cpu_start = s; cpu_we = w; cpu_addr = a; cpu_data = d;
    @(negedge clk);
    chk("gpu_we_exclusive", 32'(gpu_req & vram_we), 32'd0);
  endtask

  task automatic idle();
    cyc(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0);
  endtask

  task automatic gpu(input logic [13:0] ga);
    cyc(1'b1, ga, 1'b0, 1'b0, 14'h0, 32'h0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".cpu_q"},     cpu_q,             32'h0);
    chk({tag, ".cpu_done"},  32'(cpu_done),     32'h0);
    chk({tag, ".cpu_busy"},  32'(cpu_busy),     32'h0);
    chk({tag, ".vram_we"},   32'(vram_we),      32'h0);
    chk({tag, ".vram_addr"}, 32'(vram_addr),    32'h0);
    chk({tag, ".vram_d"},    vram_d,            32'h0);
    chk({tag, ".wait_max"},  32'(wait_max),     32'h0);
    $display("reset check [%s] done", tag);
  endtask

  vec_t tbl [19];
  int   ndone;

  initial begin
    // Write in blanking, preload via a second write, then a contended read.
    tbl[0]  = mkv(1'b0, 14'h0,    1'b1, 1'b1, 14'h0123, 32'hDEADBEEF, 1'b0, 14'h0000, 32'h00000000, 1'b0, 1'b0, 16'd0, 32'h0, 1'b0, 32'h0);
    tbl[1]  = mkv(1'b0, 14'h0,    1'b0, 1'b0, 14'h0,    32'h0,        1'b1, 14'h0123, 32'hDEADBEEF, 1'b0, 1'b1, 16'd0, 32'h0, 1'b0, 32'h0);
    tbl[2]  = mkv(1'b0, 14'h0,    1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0123, 32'hDEADBEEF, 1'b1, 1'b1, 16'd0, 32'h0, 1'b0, 32'h0);
    tbl[3]  = mkv(1'b0, 14'h0,    1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0123, 32'hDEADBEEF, 1'b0, 1'b0, 16'd0, 32'h0, 1'b0, 32'h0);
    tbl[4]  = mkv(1'b0, 14'h0,    1'b1, 1'b1, 14'h0040, 32'hCAFEF00D, 1'b0, 14'h0123, 32'hDEADBEEF, 1'b0, 1'b0, 16'd0, 32'h0, 1'b0, 32'h0);
    tbl[5]  = mkv(1'b0, 14'h0,    1'b0, 1'b0, 14'h0,    32'h0,        1'b1, 14'h0040, 32'hCAFEF00D, 1'b0, 1'b1, 16'd0, 32'h0, 1'b0, 32'h0);
    tbl[6]  = mkv(1'b0, 14'h0,    1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0040, 32'hCAFEF00D, 1'b1, 1'b1, 16'd0, 32'h0, 1'b0, 32'h0);
    tbl[7]  = mkv(1'b0, 14'h0,    1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0040, 32'hCAFEF00D, 1'b0, 1'b0, 16'd0, 32'h0, 1'b0, 32'h0);
    tbl[8]  = mkv(1'b0, 14'h0,    1'b1, 1'b0, 14'h0040, 32'h0,        1'b0, 14'h0040, 32'hCAFEF00D, 1'b0, 1'b0, 16'd0, 32'h0, 1'b0, 32'h0);
    tbl[9]  = mkv(1'b1, 14'h0100, 1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0100, 32'h0,        1'b0, 1'b1, 16'd0, 32'h0, 1'b0, 32'h0);
    tbl[10] = mkv(1'b1, 14'h0101, 1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0101, 32'h0,        1'b0, 1'b1, 16'd0, 32'h0, 1'b0, 32'h0);
    tbl[11] = mkv(1'b1, 14'h0102, 1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0102, 32'h0,        1'b0, 1'b1, 16'd0, 32'h0, 1'b1, 32'hA5000100);
    tbl[12] = mkv(1'b1, 14'h0103, 1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0103, 32'h0,        1'b0, 1'b1, 16'd0, 32'h0, 1'b1, 32'hA5000101);
    tbl[13] = mkv(1'b1, 14'h0104, 1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0104, 32'h0,        1'b0, 1'b1, 16'd0, 32'h0, 1'b1, 32'hA5000102);
    tbl[14] = mkv(1'b0, 14'h0,    1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0040, 32'h0,        1'b0, 1'b1, 16'd0, 32'h0, 1'b1, 32'hA5000103);
    tbl[15] = mkv(1'b0, 14'h0,    1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0040, 32'h0,        1'b0, 1'b1, 16'd5, 32'h0, 1'b1, 32'hA5000104);
    tbl[16] = mkv(1'b0, 14'h0,    1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0040, 32'h0,        1'b0, 1'b1, 16'd5, 32'h0, 1'b1, 32'hCAFEF00D);
    tbl[17] = mkv(1'b0, 14'h0,    1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0040, 32'h0,        1'b1, 1'b1, 16'd5, 32'hCAFEF00D, 1'b0, 32'h0);
    tbl[18] = mkv(1'b0, 14'h0,    1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 14'h0040, 32'h0,        1'b0, 1'b0, 16'd5, 32'hCAFEF00D, 1'b0, 32'h0);

    reset = 1'b1; fill = 1'b1;
    gpu_req = 1'b0; gpu_addr = '0; cpu_start = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
    @(posedge clk);
    #1 fill = 1'b0;
    @(negedge clk);
    chk_reset("por");
    @(posedge clk);
    #1 reset = 1'b0;

    // Table: uncontended writes, then a read delayed by five GPU cycles.
    for (int k = 0; k < 19; k++) begin
      cyc(tbl[k].g, tbl[k].ga, tbl[k].s, tbl[k].w, tbl[k].a, tbl[k].d);
      chk($sformatf("t%0d.vram_we", k),   32'(vram_we),   32'(tbl[k].e_we));
      chk($sformatf("t%0d.vram_addr", k), 32'(vram_addr), 32'(tbl[k].e_addr));
      chk($sformatf("t%0d.vram_d", k),    vram_d,         tbl[k].e_d);
      chk($sformatf("t%0d.cpu_done", k),  32'(cpu_done),  32'(tbl[k].e_done));
      chk($sformatf("t%0d.cpu_busy", k),  32'(cpu_busy),  32'(tbl[k].e_busy));
      chk($sformatf("t%0d.wait_max", k),  32'(wait_max),  32'(tbl[k].e_wm));
      chk($sformatf("t%0d.cpu_q", k),     cpu_q,          tbl[k].e_q);
      if (tbl[k].chk_g) chk($sformatf("t%0d.gpu_q", k), gpu_q, tbl[k].e_g);
      $display("vec %0d: gpu_req=%0b addr=%h we=%0b done=%0b busy=%0b cpu_q=%h",
               k, gpu_req, vram_addr, vram_we, cpu_done, cpu_busy, cpu_q);
    end

    // Interleave: GPU on alternate cycles, CPU read of 0x0200 in the gaps.
    cyc(1'b1, 14'h0300, 1'b1, 1'b0, 14'h0200, 32'h0);
    chk("il.s0.addr", 32'(vram_addr), 32'h0300);
    idle();
    chk("il.s1.addr", 32'(vram_addr), 32'h0200);
    chk("il.s1.we",   32'(vram_we),   32'h0);
    gpu(14'h0301);
    chk("il.s2.gpu_q", gpu_q, pat(14'h0300));
    idle();
    chk("il.s3.done", 32'(cpu_done), 32'h0);
    gpu(14'h0302);
    chk("il.s4.gpu_q", gpu_q, pat(14'h0301));
    chk("il.s4.done",  32'(cpu_done), 32'h1);
    chk("il.s4.cpu_q", cpu_q, pat(14'h0200));
    idle();
    chk("il.s5.busy",     32'(cpu_busy), 32'h0);
    chk("il.s5.wait_max", 32'(wait_max), 32'd5);
    idle();
    chk("il.s6.gpu_q", gpu_q, pat(14'h0302));
    $display("interleave sequence done");

    // Write/GPU collision: GPU claims the two cycles the write wants.
    cyc(1'b0, 14'h0, 1'b1, 1'b1, 14'h0555, 32'h12345678);
    gpu(14'h0555);
    chk("col.c1.we", 32'(vram_we), 32'h0);
    gpu(14'h0556);
    chk("col.c2.we", 32'(vram_we), 32'h0);
    idle();
    chk("col.c3.we",    32'(vram_we),   32'h1);
    chk("col.c3.addr",  32'(vram_addr), 32'h0555);
    chk("col.c3.d",     vram_d,         32'h12345678);
    chk("col.c3.gpu_q", gpu_q,          pat(14'h0555));
    idle();
    chk("col.c4.done",     32'(cpu_done), 32'h1);
    chk("col.c4.gpu_q",    gpu_q,         pat(14'h0556));
    chk("col.c4.wait_max", 32'(wait_max), 32'd5);
    gpu(14'h0555);
    idle();
    idle();
    chk("col.c7.gpu_q", gpu_q, 32'h12345678);
    $display("collision sequence done");

    // Reset pulse while a read is in flight.
    cyc(1'b0, 14'h0, 1'b1, 1'b0, 14'h0040, 32'h0);
    idle();
    chk("rst.m1.addr", 32'(vram_addr), 32'h0040);
    @(posedge clk);
    #1;
    cpu_start = 1'b0; gpu_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk_reset("mid_read");
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle();
      chk($sformatf("rst.m%0d.done", k + 3), 32'(cpu_done), 32'h0);
      chk($sformatf("rst.m%0d.busy", k + 3), 32'(cpu_busy), 32'h0);
    end
    cyc(1'b0, 14'h0, 1'b1, 1'b0, 14'h0040, 32'h0);
    idle();
    idle();
    idle();
    chk("rst.n3.done", 32'(cpu_done), 32'h0);
    idle();
    chk("rst.n4.done",  32'(cpu_done), 32'h1);
    chk("rst.n4.cpu_q", cpu_q,         32'hCAFEF00D);
    $display("reset mid-read sequence done");

    // Back-to-back starts while busy must be ignored.
    ndone = 0;
    cyc(1'b0, 14'h0, 1'b1, 1'b1, 14'h0700, 32'h0BADCAFE);
    ndone += int'(cpu_done);
    cyc(1'b0, 14'h0, 1'b1, 1'b1, 14'h0701, 32'h11111111);
    ndone += int'(cpu_done);
    chk("b2b.b1.we",   32'(vram_we),   32'h1);
    chk("b2b.b1.addr", 32'(vram_addr), 32'h0700);
    chk("b2b.b1.d",    vram_d,         32'h0BADCAFE);
    cyc(1'b0, 14'h0, 1'b1, 1'b1, 14'h0702, 32'h22222222);
    ndone += int'(cpu_done);
    chk("b2b.b2.done", 32'(cpu_done), 32'h1);
    idle();
    ndone += int'(cpu_done);
    chk("b2b.b3.we",   32'(vram_we),  32'h0);
    chk("b2b.b3.busy", 32'(cpu_busy), 32'h0);
    idle();
    ndone += int'(cpu_done);
    chk("b2b.b4.we", 32'(vram_we), 32'h0);
    chk("b2b.ndone", 32'(ndone),   32'd1);
    gpu(14'h0701);
    gpu(14'h0702);
    gpu(14'h0700);
    chk("b2b.g2.gpu_q", gpu_q, pat(14'h0701));
    idle();
    chk("b2b.g3.gpu_q", gpu_q, pat(14'h0702));
    idle();
    chk("b2b.g4.gpu_q", gpu_q, 32'h0BADCAFE);
    $display("back-to-back sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Shares one synchronous VRAM port (VRAM32, VRAM8 or VRAMSPR) between the GPU renderer's read fetches and CPU memory-mapped accesses. The GPU has absolute priority and sees the RAM with unchanged address-to-data latency. The CPU uses a start/done handshake and is served only in cycles the GPU leaves idle, mainly during blanking. The block sits between the GPU pixel pipeline, the CPU bus bridge and the VRAM instance, all in the GPU clock domain.

## Interface
- ADDR_W, 14, VRAM address width
- DATA_W, 32, VRAM data width (8 for VRAM8, 9 for VRAMSPR)
- RD_LAT, 1, VRAM read latency in cycles, address to q; legal range 1..3
- clk  in  1  GPU clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- gpu_req  in  1  GPU read request this cycle
- gpu_addr  in  ADDR_W  GPU read address
- gpu_q  out  DATA_W  GPU read data; equals vram_q, valid RD_LAT cycles after gpu_req
- cpu_start  in  1  single-cycle pulse starting a CPU access
- cpu_we  in  1  write when 1, read when 0; sampled with cpu_start
- cpu_addr  in  ADDR_W  sampled with cpu_start
- cpu_data  in  DATA_W  write data, sampled with cpu_start
- cpu_q  out  DATA_W  CPU read data; holds until the next CPU read completes
- cpu_done  out  1  one-cycle pulse when the access completes
- cpu_busy  out  1  high from the cycle after cpu_start until the cycle of cpu_done
- vram_addr  out  ADDR_W  to VRAM
- vram_d  out  DATA_W  to VRAM
- vram_we  out  1  to VRAM
- vram_q  in  DATA_W  from VRAM
- wait_max  out  16  largest number of cycles any CPU access has waited for a slot since reset; saturates at 0xFFFF

## Operation
- The control FSM has three states: IDLE, PEND, RDWAIT.
- IDLE
  - On cpu_start, latch cpu_we, cpu_addr and cpu_data, clear the wait counter and go to PEND.
  - cpu_start is ignored while cpu_busy is high.
- PEND: each cycle, if gpu_req is high, the GPU owns the port and the wait counter increments (saturating). Otherwise the CPU owns the port:
  - Write: drive vram_we=1 with the latched address and data. Assert cpu_done in the next cycle and return to IDLE.
  - Read: drive the latched address with vram_we=0, push a CPU tag into the read tag pipeline and go to RDWAIT.
- RDWAIT
  - The GPU may use the port freely.
  - When the CPU tag leaves the tag pipeline (RD_LAT cycles after the issue cycle), capture vram_q into cpu_q, pulse cpu_done and go to IDLE.
- Tag pipeline: a 1-bit shift register RD_LAT deep, shifted every cycle. It is the only thing that separates CPU read data from GPU read data.
- Port mux: when gpu_req is high, vram_addr=gpu_addr and vram_we=0, whatever the FSM state. vram_we is never 1 in a cycle where gpu_req is 1.
- Idle port: with no owner, vram_addr holds the last driven value and vram_we=0.
- wait_max updates on every CPU grant: wait_max = max(wait_max, wait counter).

## Timing
- Reset values: cpu_q=0, cpu_done=0, cpu_busy=0, vram_we=0, vram_addr=0, vram_d=0, wait_max=0, FSM in IDLE, tag pipeline cleared.
- vram_addr, vram_we and vram_d are combinational from gpu_req, gpu_addr and FSM state. This adds zero cycles to the GPU path.
- Uncontended write: cpu_start at cycle 0, vram_we=1 at cycle 1, cpu_done at cycle 2.
- Uncontended read: address issued at cycle 1, cpu_done and cpu_q valid at cycle 1+RD_LAT+1. The capture is registered.
- Contended access: every cycle with gpu_req=1 in PEND adds exactly one cycle of latency.
- Starvation: if gpu_req stays high continuously, the CPU waits indefinitely. The block has no timeout; blanking guarantees a slot.
- cpu_start arriving in the same cycle as cpu_done is ignored. The requester must wait for cpu_busy=0.
- Reset asserted mid-access:
  - the access is dropped and no cpu_done is produced;
  - a write that has not yet been granted never reaches VRAM;
  - a read already issued is discarded, because its tag is cleared.

## Structure
- A shared gpu_pkg holds the FSM state encoding (ARB_IDLE, ARB_PEND, ARB_RDWAIT) and the default widths. The GPU top-level and the other VRAM clients reuse these.
- One sub-module, rd_tag_pipe: a parameterised RD_LAT-deep 1-bit shift register with asynchronous clear. It is reused by later clients that share the same latency scheme.

## Test plan
- Write in blanking: gpu_req=0, write 0xDEADBEEF to 0x0123 → vram_we high for exactly one cycle with addr 0x0123 and d 0xDEADBEEF; cpu_done 2 cycles after start; wait_max=0.
- Read contention: preload 0x0040=0xCAFEF00D, gpu_req high for 5 cycles, then CPU read 0x0040 → grant after 5 wait cycles; cpu_q=0xCAFEF00D; wait_max=5; GPU data stream uncorrupted.
- Interleave at RD_LAT=2: GPU requests every other cycle, alternating with a CPU read → each GPU fetch returns its own address's data 2 cycles later, and the CPU gets its own word.
- Write/GPU collision: gpu_req asserted in the exact cycle a write would be granted → vram_we=0 that cycle; the write lands on the first free cycle; no GPU read ever sees vram_we=1.
- Reset mid-read: assert reset in RDWAIT → no cpu_done pulse; all outputs return to reset values; the next read completes normally.
- Back-to-back: a cpu_start arriving while cpu_busy=1 is ignored, and only one cpu_done is produced.
